// File: rtl/uart_rx_fifo_pkg.sv
// Shared definitions for the UART receive path: byte width and the stored frame layout.
package uart_pkg;

    localparam int unsigned UART_DATA_W = 8;
    localparam int unsigned PAR_ERR_BIT = UART_DATA_W;
    localparam int unsigned STP_ERR_BIT = UART_DATA_W + 1;
    localparam int unsigned FRAME_W     = UART_DATA_W + 2;

    typedef struct packed {
        logic                   stp_err;
        logic                   par_err;
        logic [UART_DATA_W-1:0] data;
    } frame_t;

endpackage

// File: rtl/uart_rx_fifo_core.sv
// Generic synchronous FIFO with first-word-fall-through read; the head word reads as zero while empty.
module sync_fifo_core #(
    parameter int unsigned WIDTH = 10,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     wr_en_i,
    input  logic [WIDTH-1:0]         wr_data_i,
    input  logic                     rd_en_i,
    output logic [WIDTH-1:0]         rd_data_o,
    output logic                     empty_o,
    output logic                     full_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             empty_q, full_q;
    logic             do_wr, do_rd;

    // A pop in the same cycle frees the slot a write into a full FIFO needs.
    always_comb begin
        do_rd    = rd_en_i & ~empty_q;
        do_wr    = wr_en_i & (~full_q | do_rd);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_wr) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_rd) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_wr, do_rd})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            empty_q  <= (count_d == '0);
            full_q   <= (count_d == DEPTH_C);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i && do_wr) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    assign rd_data_o = empty_q ? '0 : mem_q[rd_ptr_q];
    assign empty_o   = empty_q;
    assign full_o    = full_q;
    assign count_o   = count_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive frame buffer: edge-detected capture of byte plus error flags, optional error-frame drop,
// sticky overflow and a saturating error counter around a FWFT FIFO.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned DROP_ERR = 0,
    parameter int unsigned CNT_W    = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [7:0]             P_DATA,
    input  logic                   data_valid,
    input  logic                   par_err,
    input  logic                   stp_err,
    input  logic                   rd_en,
    input  logic                   ovf_clr,
    input  logic                   err_cnt_clr,
    output logic [7:0]             rd_data,
    output logic                   rd_par_err,
    output logic                   rd_stp_err,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow
    ,
    output logic [CNT_W-1:0]       err_cnt
);

    logic             data_valid_q;
    logic             overflow_q, overflow_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic             push, err, wr_req, lost;
    frame_t           wr_frame, head;
    logic             fifo_full, fifo_empty;

    always_comb begin
        push     = data_valid & ~data_valid_q;
        err      = push & (par_err | stp_err);
        wr_req   = push & ~((DROP_ERR != 0) & err);
        // Full implies non-empty, so any rd_en alongside a full push makes room.
        lost     = wr_req & fifo_full & ~rd_en;

        wr_frame         = '0;
        wr_frame.stp_err = stp_err;
        wr_frame.par_err = par_err;
        wr_frame.data    = P_DATA;

        overflow_d = overflow_q;
        if (lost) begin
            overflow_d = 1'b1;
        end else if (ovf_clr) begin
            overflow_d = 1'b0;
        end

        err_cnt_d = err_cnt_q;
        if (err_cnt_clr) begin
            err_cnt_d = '0;
        end else if (err && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_valid_q <= 1'b0;
            overflow_q   <= 1'b0;
            err_cnt_q    <= '0;
        end else begin
            data_valid_q <= data_valid;
            overflow_q   <= overflow_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    sync_fifo_core #(
        .WIDTH (FRAME_W),
        .DEPTH (DEPTH)
    ) u_core (
        .clk_i     (clk),
        .rst_i     (rst),
        .wr_en_i   (wr_req),
        .wr_data_i (wr_frame),
        .rd_en_i   (rd_en),
        .rd_data_o (head),
        .empty_o   (fifo_empty),
        .full_o    (fifo_full),
        .count_o   (count)
    );

    assign rd_data    = head.data;
    assign rd_par_err = head.par_err;
    assign rd_stp_err = head.stp_err;
    assign empty      = fifo_empty;
    assign full       = fifo_full;
    assign overflow   = overflow_q;
    assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: one instance storing errored frames, one dropping them, fed the same stimulus.
module tb_uart_rx_fifo;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] P_DATA;
    logic       data_valid, par_err, stp_err, rd_en, ovf_clr, err_cnt_clr;

    logic [7:0] rd_data, d_rd_data;
    logic       rd_par_err, rd_stp_err, empty, full, overflow;
    logic       d_rd_par_err, d_rd_stp_err, d_empty, d_full, d_overflow;
    logic [3:0] count, d_count;
    logic [7:0] err_cnt, d_err_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    uart_rx_fifo #(.DEPTH(8), .DROP_ERR(0), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .P_DATA(P_DATA), .data_valid(data_valid),
        .par_err(par_err), .stp_err(stp_err), .rd_en(rd_en), .ovf_clr(ovf_clr),
        .err_cnt_clr(err_cnt_clr), .rd_data(rd_data), .rd_par_err(rd_par_err),
        .rd_stp_err(rd_stp_err), .empty(empty), .full(full), .count(count),
        .overflow(overflow), .err_cnt(err_cnt)
    );

    uart_rx_fifo #(.DEPTH(8), .DROP_ERR(1), .CNT_W(8)) dut_drop (
        .clk(clk), .rst(rst), .P_DATA(P_DATA), .data_valid(data_valid),
        .par_err(par_err), .stp_err(stp_err), .rd_en(rd_en), .ovf_clr(ovf_clr),
        .err_cnt_clr(err_cnt_clr), .rd_data(d_rd_data), .rd_par_err(d_rd_par_err),
        .rd_stp_err(d_rd_stp_err), .empty(d_empty), .full(d_full), .count(d_count),
        .overflow(d_overflow), .err_cnt(d_err_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b, input logic pe, input logic se);
        P_DATA     = b;
        par_err    = pe;
        stp_err    = se;
        data_valid = 1'b1;
        tick();
        data_valid = 1'b0;
        par_err    = 1'b0;
        stp_err    = 1'b0;
        tick();
    endtask

    task automatic pop();
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
    endtask

    initial begin
        rst = 1'b1; P_DATA = '0; data_valid = 1'b0; par_err = 1'b0; stp_err = 1'b0;
        rd_en = 1'b0; ovf_clr = 1'b0; err_cnt_clr = 1'b0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_count", count, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_errcnt", err_cnt, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_flags", {rd_stp_err, rd_par_err}, 0);

        // Three clean frames, in-order FWFT reads
        P_DATA = 8'hA5; data_valid = 1'b1;
        tick();
        chk("first_push_empty", empty, 0);
        chk("first_push_head", rd_data, 8'hA5);
        data_valid = 1'b0;
        tick();
        push(8'h3C, 0, 0);
        push(8'hFF, 0, 0);
        chk("three_count", count, 3);
        chk("pop0_data", rd_data, 8'hA5);
        chk("pop0_flags", {rd_stp_err, rd_par_err}, 0);
        pop();
        chk("pop1_data", rd_data, 8'h3C);
        pop();
        chk("pop2_data", rd_data, 8'hFF);
        pop();
        chk("drained_empty", empty, 1);
        chk("drained_count", count, 0);
        pop();
        chk("pop_on_empty_count", count, 0);

        // Fill to DEPTH, then overflow with 0x77
        for (int i = 0; i < 8; i++) push(8'h20 + 8'(i), 0, 0);
        chk("fill_full", full, 1);
        chk("fill_count", count, 8);
        chk("fill_ovf", overflow, 0);
        chk("fill_empty", empty, 0);
        push(8'h77, 0, 0);
        chk("ovf_set", overflow, 1);
        chk("ovf_count", count, 8);
        chk("ovf_full", full, 1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("ovf_cleared", overflow, 0);

        // Push with pop while full
        P_DATA = 8'h11; data_valid = 1'b1; rd_en = 1'b1;
        tick();
        data_valid = 1'b0; rd_en = 1'b0;
        chk("pp_full", full, 1);
        chk("pp_ovf", overflow, 0);
        chk("pp_count", count, 8);
        tick();
        for (int i = 0; i < 7; i++) begin
            chk($sformatf("drain_%0d", i), rd_data, 8'h21 + 8'(i));
            pop();
        end
        chk("drain_last_0x11", rd_data, 8'h11);
        pop();
        chk("drain_empty", empty, 1);

        // Error frames: stored vs dropped
        push(8'h55, 1, 0);
        chk("par_data", rd_data, 8'h55);
        chk("par_flag", rd_par_err, 1);
        chk("par_stp_flag", rd_stp_err, 0);
        chk("par_errcnt", err_cnt, 1);
        chk("drop_par_empty", d_empty, 1);
        chk("drop_par_errcnt", d_err_cnt, 1);
        chk("drop_par_ovf", d_overflow, 0);
        err_cnt_clr = 1'b1;
        tick();
        err_cnt_clr = 1'b0;
        chk("errcnt_clr", err_cnt, 0);
        push(8'h66, 0, 1);
        chk("drop_stp_empty", d_empty, 1);
        chk("drop_stp_errcnt", d_err_cnt, 1);
        chk("keep_stp_count", count, 2);
        chk("keep_stp_errcnt", err_cnt, 1);
        err_cnt_clr = 1'b1;
        push(8'h67, 0, 1);
        err_cnt_clr = 1'b0;
        chk("clr_priority", err_cnt, 0);
        chk("clr_priority_drop", d_err_cnt, 0);
        chk("e0_flags", {rd_stp_err, rd_par_err, rd_data}, {2'b01, 8'h55});
        pop();
        chk("e1_flags", {rd_stp_err, rd_par_err, rd_data}, {2'b10, 8'h66});
        pop();
        chk("e2_flags", {rd_stp_err, rd_par_err, rd_data}, {2'b10, 8'h67});
        pop();
        chk("err_drained", empty, 1);

        // Level held for 5 cycles is one frame
        P_DATA = 8'h42; data_valid = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        data_valid = 1'b0;
        tick();
        chk("level_count", count, 1);
        chk("level_data", rd_data, 8'h42);
        pop();
        chk("level_empty", empty, 1);

        // Saturating error counter
        for (int i = 0; i < 254; i++) push(8'(i), 1, 0);
        chk("sat_254", err_cnt, 8'hFE);
        push(8'hC0, 0, 1);
        chk("sat_255", err_cnt, 8'hFF);
        push(8'hC1, 1, 1);
        chk("sat_256", err_cnt, 8'hFF);
        chk("sat_drop_errcnt", d_err_cnt, 8'hFF);
        chk("sat_ovf", overflow, 1);
        chk("sat_count", count, 8);
        chk("sat_drop_empty", d_empty, 1);
        chk("sat_drop_ovf", d_overflow, 0);

        // Reset mid-operation with data_valid held high
        for (int i = 0; i < 4; i++) pop();
        chk("mid_count4", count, 4);
        P_DATA = 8'h9A; data_valid = 1'b1; rst = 1'b1;
        tick();
        chk("mid_rst_count", count, 0);
        chk("mid_rst_empty", empty, 1);
        chk("mid_rst_full", full, 0);
        chk("mid_rst_ovf", overflow, 0);
        chk("mid_rst_errcnt", err_cnt, 0);
        rst = 1'b0;
        tick();
        chk("post_rst_push", count, 1);
        chk("post_rst_data", rd_data, 8'h9A);
        tick();
        chk("post_rst_single", count, 1);
        data_valid = 1'b0;
        tick();
        chk("post_rst_final", count, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
